// File: rtl/hex8_disp_scan.sv
// hex8_disp_scan: 8-digit multiplexed 7-segment driver (common anode, active-low).
// Inputs are snapshotted once per scan frame so mid-frame edits never tear the display.
// Optional: define HEX8_DISP_LZ_BLANK_EN to suppress leading zero digits.
module hex8_disp_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hex_data,
    input  logic [7:0]  blink,
    input  logic [7:0]  point,
    input  logic [7:0]  le,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_tick
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // Hex nibble to gfedcba, active-low
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef HEX8_DISP_LZ_BLANK_EN
    // Digits at or below the highest non-zero nibble stay visible; digit 0 always does
    function automatic logic [7:0] lz_mask(input logic [31:0] d);
        logic [7:0] m;
        logic       seen;
        m    = 8'h00;
        seen = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            seen = seen | (d[i*4 +: 4] != 4'h0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction
`endif

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             phase;
    logic [31:0]      data_s;
    logic [7:0]       blink_s;
    logic [7:0]       point_s;
    logic [7:0]       le_s;
`ifdef HEX8_DISP_LZ_BLANK_EN
    logic [7:0]       lz_s;
`endif

    logic             div_wrap;
    logic             snap;
    logic [DIV_W-1:0] div_nxt;
    logic [2:0]       idx_nxt;
    logic             tick_nxt;
    logic             vis;
    logic [3:0]       nib;
    logic [7:0]       an_nxt;
    logic [7:0]       seg_nxt;

    // Scan sequencing, snapshot strobe and next output pattern
    always_comb begin
        div_wrap = 1'b0;
        snap     = 1'b0;
        div_nxt  = div;
        idx_nxt  = idx;
        tick_nxt = 1'b0;
        vis      = 1'b0;
        nib      = 4'h0;
        an_nxt   = 8'hFF;
        seg_nxt  = 8'hFF;

        div_wrap = (div == DIV_LAST);
        snap     = div_wrap && (idx == 3'd7);
        div_nxt  = div_wrap ? '0 : div + DIV_W'(1);
        idx_nxt  = div_wrap ? idx + 3'd1 : idx;
        // Registered one cycle early so the pulse lands on the snapshot cycle itself
        tick_nxt = (div_nxt == DIV_LAST) && (idx_nxt == 3'd7);

        vis = le_s[idx] & ~(blink_s[idx] & ~phase);
`ifdef HEX8_DISP_LZ_BLANK_EN
        vis = vis & lz_s[idx];
`endif
        nib = data_s[{idx, 2'b00} +: 4];
        if (vis) begin
            an_nxt  = ~(8'd1 << idx);
            seg_nxt = {~point_s[idx], seg7(nib)};
        end
    end

    // State, shadow registers and glitch-free registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            idx        <= 3'd0;
            frame_cnt  <= '0;
            phase      <= 1'b1;
            data_s     <= 32'h0;
            blink_s    <= 8'h00;
            point_s    <= 8'h00;
            le_s       <= 8'h00;
`ifdef HEX8_DISP_LZ_BLANK_EN
            lz_s       <= 8'h00;
`endif
            AN         <= 8'hFF;
            SEGMENT    <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_nxt;
            idx        <= idx_nxt;
            AN         <= an_nxt;
            SEGMENT    <= seg_nxt;
            frame_tick <= tick_nxt;
            if (snap) begin
                data_s  <= hex_data;
                blink_s <= blink;
                point_s <= point;
                le_s    <= le;
`ifdef HEX8_DISP_LZ_BLANK_EN
                lz_s    <= lz_mask(hex_data);
`endif
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
        end
    end

endmodule
